bcd_countdown_timer: RTL and testbench

Parametrised countdown core for the egg-timer board. Takes NUM_FIELDS two-digit BCD fields, entered one at a time from an 8-bit switch value with a load pushbutton. Counts down in mm:ss-style base-60/base-100 BCD and raises a blinking alarm at zero. Adds pause/resume, input validation and configurable field count over the fixed two-field timer; sits between the KEY/SW inputs and the HEX/LED decoders.

---
 rtl/egg_timer_pkg.sv | 31 +++
 rtl/key_press_sync.sv | 68 ++++++
 rtl/bcd_countdown_timer.sv | 221 ++++++++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/egg_timer_pkg.sv
// Shared definitions for the egg-timer countdown core: state encoding,
// BCD field constants and the field-validity check used on every LOAD.
package egg_timer_pkg;

   localparam int FIELD_W = 8;
   localparam int DIGIT_W = 4;
   localparam logic [3:0] BCD_MAX_UNIT     = 4'd9;
   localparam logic [3:0] BCD_MAX_TENS_B60 = 4'd5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ENTRY = 3'd1,
      ST_ARMED = 3'd2,
      ST_RUN   = 3'd3,
      ST_PAUSE = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   // Both nibbles must be decimal; base-60 fields also cap the tens digit at 5.
   function automatic logic field_valid(input logic [FIELD_W-1:0] value, input logic is_top);
      logic ok;
      ok = (value[7:4] <= BCD_MAX_UNIT) && (value[3:0] <= BCD_MAX_UNIT);
      if (!is_top && (value[7:4] > BCD_MAX_TENS_B60)) begin
         ok = 1'b0;
      end else begin
         ok = ok;
      end
      return ok;
   endfunction

endpackage

// File: rtl/key_press_sync.sv
// Pushbutton front end: 2-flop synchroniser and one-cycle press pulse on the
// falling edge. Defining DEBOUNCE_EN adds a stable-low qualification counter.
module key_press_sync #(
   parameter int DEBOUNCE_CYCLES = 250000
)(
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   logic sync1_r;
   logic sync2_r;

   // Two-stage synchroniser; idle level of the key is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= key_n;
         sync2_r <= sync1_r;
      end
   end

`ifdef DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

   logic [CNT_W-1:0] cnt_r;
   logic             fired_r;

   // Count stable-low cycles; fired_r blocks repeats until the key is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r   <= {CNT_W{1'b0}};
         fired_r <= 1'b0;
      end else if (sync2_r) begin
         cnt_r   <= {CNT_W{1'b0}};
         fired_r <= 1'b0;
      end else if (!fired_r) begin
         if (cnt_r == CNT_DONE) begin
            fired_r <= 1'b1;
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign press = ~sync2_r & ~fired_r & (cnt_r == CNT_DONE);
`else
   logic prev_r;

   // Previous synchronised level for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_r <= 1'b1;
      end else begin
         prev_r <= sync2_r;
      end
   end

   assign press = prev_r & ~sync2_r;
`endif

endmodule

// File: rtl/bcd_countdown_timer.sv
// Parametrised BCD countdown core with entry, pause/resume and blinking alarm.
// Optional key debounce is enabled by defining DEBOUNCE_EN.
module bcd_countdown_timer #(
   parameter int NUM_FIELDS      = 2,
   parameter int CLK_HZ          = 50000000,
   parameter int TICK_HZ         = 1,
   parameter int BLINK_CYCLES    = 12500000,
   parameter int DEBOUNCE_CYCLES = 250000
)(
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    LOAD_KEY_N,
   input  logic                    START_KEY_N,
   input  logic [7:0]              SET_VAL,
   output logic [8*NUM_FIELDS-1:0] DIGITS,
   output logic [2:0]              STATE,
   output logic                    RUNNING,
   output logic                    DONE,
   output logic                    ALARM,
   output logic                    INVALID
);
   import egg_timer_pkg::*;

   localparam int DW      = FIELD_W * NUM_FIELDS;
   localparam int DIV_RAW = CLK_HZ / TICK_HZ;
   localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
   localparam int PS_W    = $clog2(DIV);
   localparam int BL_W    = (BLINK_CYCLES < 2) ? 1 : $clog2(BLINK_CYCLES);
   localparam int IDX_W   = (NUM_FIELDS < 2) ? 1 : $clog2(NUM_FIELDS);

   localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_FIELDS - 1);
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(DIV - 1);
   localparam logic [BL_W-1:0]  BL_LAST = BL_W'(BLINK_CYCLES - 1);
   localparam logic [DW-1:0]    ZERO    = {DW{1'b0}};

   logic             load_press_s;
   logic             start_press_s;
   state_e           state_r, state_n;
   logic [DW-1:0]    digits_r, digits_n, dec_s;
   logic [IDX_W-1:0] idx_r, idx_n, load_idx_s;
   logic [PS_W-1:0]  prescale_r, prescale_n;
   logic [BL_W-1:0]  blink_r, blink_n;
   logic             alarm_r, alarm_n;
   logic             invalid_r, invalid_n;
   logic             running_r, done_r;
   logic [NUM_FIELDS-1:0] borrow_s;

   key_press_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_key (
      .clk   (CLK),
      .rst_n (RST_N),
      .key_n (LOAD_KEY_N),
      .press (load_press_s)
   );

   key_press_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_key (
      .clk   (CLK),
      .rst_n (RST_N),
      .key_n (START_KEY_N),
      .press (start_press_s)
   );

   // Decremented count: field 0 always takes the borrow, the chain ripples up.
   assign borrow_s[0] = 1'b1;
   for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
      localparam logic [3:0] TENS_MAX = (f == NUM_FIELDS - 1) ? BCD_MAX_UNIT : BCD_MAX_TENS_B60;
      logic [DIGIT_W-1:0] units_s, tens_s, units_dec_s, tens_dec_s;

      assign units_s = digits_r[f*FIELD_W +: DIGIT_W];
      assign tens_s  = digits_r[f*FIELD_W + DIGIT_W +: DIGIT_W];

      // Per-field BCD decrement with wrap to 9 (units) or the field's tens limit.
      always_comb begin
         units_dec_s = units_s;
         tens_dec_s  = tens_s;
         if (borrow_s[f]) begin
            if (units_s == 4'd0) begin
               units_dec_s = BCD_MAX_UNIT;
               if (tens_s == 4'd0) begin
                  tens_dec_s = TENS_MAX;
               end else begin
                  tens_dec_s = tens_s - 4'd1;
               end
            end else begin
               units_dec_s = units_s - 4'd1;
            end
         end else begin
            units_dec_s = units_s;
         end
      end

      assign dec_s[f*FIELD_W +: FIELD_W] = {tens_dec_s, units_dec_s};

      if (f < NUM_FIELDS - 1) begin : g_borrow
         assign borrow_s[f+1] = borrow_s[f] & (units_s == 4'd0) & (tens_s == 4'd0);
      end
   end

   // Re-arming from ARMED or DONE always restarts at the top field.
   assign load_idx_s = ((state_r == ST_ARMED) || (state_r == ST_DONE)) ? TOP_IDX : idx_r;

   // Next-state and datapath decode; START wins over a coincident LOAD.
   always_comb begin
      state_n    = state_r;
      digits_n   = digits_r;
      idx_n      = idx_r;
      invalid_n  = invalid_r;
      prescale_n = prescale_r;
      if (state_r == ST_DONE) begin
         if (blink_r == BL_LAST) begin
            blink_n = {BL_W{1'b0}};
            alarm_n = ~alarm_r;
         end else begin
            blink_n = blink_r + BL_W'(1);
            alarm_n = alarm_r;
         end
      end else begin
         blink_n = {BL_W{1'b0}};
         alarm_n = 1'b0;
      end

      case (state_r)
         ST_IDLE, ST_ENTRY, ST_ARMED, ST_DONE: begin
            if (start_press_s) begin
               if ((state_r == ST_ARMED) && (digits_r != ZERO)) begin
                  state_n    = ST_RUN;
                  prescale_n = {PS_W{1'b0}};
               end else if (state_r == ST_DONE) begin
                  state_n = ST_IDLE;
                  blink_n = {BL_W{1'b0}};
                  alarm_n = 1'b0;
               end else begin
                  state_n = state_r;
               end
            end else if (load_press_s) begin
               if (field_valid(SET_VAL, load_idx_s == TOP_IDX)) begin
                  digits_n[load_idx_s*FIELD_W +: FIELD_W] = SET_VAL;
                  invalid_n = 1'b0;
                  blink_n   = {BL_W{1'b0}};
                  alarm_n   = 1'b0;
                  if (load_idx_s == {IDX_W{1'b0}}) begin
                     state_n = ST_ARMED;
                     idx_n   = TOP_IDX;
                  end else begin
                     state_n = ST_ENTRY;
                     idx_n   = load_idx_s - IDX_W'(1);
                  end
               end else begin
                  invalid_n = 1'b1;
               end
            end else begin
               state_n = state_r;
            end
         end
         ST_RUN: begin
            if (prescale_r == PS_LAST) begin
               prescale_n = {PS_W{1'b0}};
               digits_n   = dec_s;
               if (dec_s == ZERO) begin
                  state_n = ST_DONE;
                  alarm_n = 1'b1;
                  blink_n = {BL_W{1'b0}};
               end else if (start_press_s) begin
                  state_n = ST_PAUSE;
               end else begin
                  state_n = state_r;
               end
            end else begin
               prescale_n = prescale_r + PS_W'(1);
               if (start_press_s) begin
                  state_n = ST_PAUSE;
               end else begin
                  state_n = state_r;
               end
            end
         end
         ST_PAUSE: begin
            if (start_press_s) begin
               state_n = ST_RUN;
            end else begin
               state_n = state_r;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; status flags are registered from next state.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r    <= ST_IDLE;
         digits_r   <= ZERO;
         idx_r      <= TOP_IDX;
         invalid_r  <= 1'b0;
         prescale_r <= {PS_W{1'b0}};
         blink_r    <= {BL_W{1'b0}};
         alarm_r    <= 1'b0;
         running_r  <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_n;
         digits_r   <= digits_n;
         idx_r      <= idx_n;
         invalid_r  <= invalid_n;
         prescale_r <= prescale_n;
         blink_r    <= blink_n;
         alarm_r    <= alarm_n;
         running_r  <= (state_n == ST_RUN);
         done_r     <= (state_n == ST_DONE);
      end
   end

   assign DIGITS  = digits_r;
   assign STATE   = state_r;
   assign RUNNING = running_r;
   assign DONE    = done_r;
   assign ALARM   = alarm_r;
   assign INVALID = invalid_r;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: a seconds-based reference model checked every
// cycle, plus directed literal checks at the scenario milestones.
module tb_bcd_countdown_timer;

   localparam int NF    = 2;
   localparam int DIV   = 10;
   localparam int BLINK = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        load_key_n = 1'b1;
   logic        start_key_n = 1'b1;
   logic [7:0]  set_val = 8'h00;
   logic [15:0] digits;
   logic [2:0]  state;
   logic        running, done, alarm, invalid;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   always #5 clk = ~clk;

   bcd_countdown_timer #(
      .NUM_FIELDS(NF), .CLK_HZ(10), .TICK_HZ(1), .BLINK_CYCLES(BLINK), .DEBOUNCE_CYCLES(3)
   ) dut (
      .CLK(clk), .RST_N(rst_n), .LOAD_KEY_N(load_key_n), .START_KEY_N(start_key_n),
      .SET_VAL(set_val), .DIGITS(digits), .STATE(state), .RUNNING(running),
      .DONE(done), .ALARM(alarm), .INVALID(invalid)
   );

   // Reference model: fields held as decimal numbers, count handled as seconds.
   int m_state = 0, m_idx = 1, m_pre = 0, m_done_cyc = 0;
   int m_fld[2] = '{0, 0};
   bit m_inv = 1'b0;
   bit ld_h1 = 1'b1, ld_h2 = 1'b1, ld_h3 = 1'b1;
   bit st_h1 = 1'b1, st_h2 = 1'b1, st_h3 = 1'b1;

   function automatic int from_bcd(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   task automatic cmp(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      bit ld, st, ok;
      int tot, prev, i;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_state = 0; m_idx = 1; m_pre = 0; m_done_cyc = 0; m_inv = 1'b0;
            m_fld[0] = 0; m_fld[1] = 0;
            ld_h1 = 1'b1; ld_h2 = 1'b1; ld_h3 = 1'b1;
            st_h1 = 1'b1; st_h2 = 1'b1; st_h3 = 1'b1;
         end else begin
            // A pin fall is seen by the FSM on the third edge after it.
            ld = !ld_h2 && ld_h3;
            st = !st_h2 && st_h3;
            ld_h3 = ld_h2; ld_h2 = ld_h1; ld_h1 = load_key_n;
            st_h3 = st_h2; st_h2 = st_h1; st_h1 = start_key_n;
            prev = m_state;
            tot = m_fld[1] * 60 + m_fld[0];
            case (m_state)
               0, 1, 2, 5: begin
                  if (st) begin
                     if (m_state == 2 && tot != 0) begin
                        m_state = 3; m_pre = 0;
                     end else if (m_state == 5) begin
                        m_state = 0;
                     end
                  end else if (ld) begin
                     i = (m_state == 2 || m_state == 5) ? 1 : m_idx;
                     ok = (set_val[7:4] <= 4'd9) && (set_val[3:0] <= 4'd9) &&
                          (i == 1 || from_bcd(set_val) <= 59);
                     if (ok) begin
                        m_fld[i] = from_bcd(set_val);
                        m_inv = 1'b0;
                        if (i == 0) begin m_state = 2; m_idx = 1; end
                        else begin m_state = 1; m_idx = i - 1; end
                     end else begin
                        m_inv = 1'b1;
                     end
                  end
               end
               3: begin
                  if (m_pre == DIV - 1) begin
                     m_pre = 0;
                     tot = tot - 1;
                     m_fld[1] = tot / 60;
                     m_fld[0] = tot % 60;
                     if (tot == 0) m_state = 5;
                     else if (st) m_state = 4;
                  end else begin
                     m_pre = m_pre + 1;
                     if (st) m_state = 4;
                  end
               end
               4: if (st) m_state = 3;
               default: m_state = 0;
            endcase
            if (m_state == 5 && prev == 5) m_done_cyc = m_done_cyc + 1;
            else m_done_cyc = 0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model, on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            cmp("cyc_digits",  int'(digits),  int'({to_bcd(m_fld[1]), to_bcd(m_fld[0])}));
            cmp("cyc_state",   int'(state),   m_state);
            cmp("cyc_running", int'(running), int'(m_state == 3));
            cmp("cyc_done",    int'(done),    int'(m_state == 5));
            cmp("cyc_alarm",   int'(alarm),   int'(m_state == 5 && ((m_done_cyc / BLINK) % 2 == 0)));
            cmp("cyc_invalid", int'(invalid), int'(m_inv));
         end
      end
   end

   task automatic press(input bit l, input bit s);
      @(negedge clk);
      if (l) load_key_n = 1'b0;
      if (s) start_key_n = 1'b0;
      repeat (3) @(negedge clk);
      load_key_n = 1'b1;
      start_key_n = 1'b1;
   endtask

   task automatic load(input logic [7:0] v);
      set_val = v;
      press(1'b1, 1'b0);
   endtask

   task automatic expect_ds(input string nm, input int d, input int s);
      cmp({nm, "_digits"}, int'(digits), d);
      cmp({nm, "_state"},  int'(state),  s);
   endtask

   initial begin
      // Reset asserted mid-clock takes effect before the next edge.
      #12 rst_n = 1'b0;
      #1;
      expect_ds("reset", 16'h0000, 0);
      cmp("reset_flags", int'({running, done, alarm, invalid}), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Entry of two fields.
      load(8'h59); expect_ds("entry1", 16'h5900, 1);
      load(8'h10); expect_ds("entry2", 16'h5910, 2);

      // Validation in ENTRY.
      load(8'h12); expect_ds("val_top", 16'h1210, 1);
      load(8'h60); expect_ds("val_60", 16'h1210, 1);
      cmp("val_60_inv", int'(invalid), 1);
      load(8'h3A); cmp("val_3a_inv", int'(invalid), 1);
      load(8'h45); expect_ds("val_45", 16'h1245, 2);
      cmp("val_45_inv", int'(invalid), 0);

      // Borrow across fields and the alarm blink.
      load(8'h01); load(8'h00); expect_ds("b_load", 16'h0100, 2);
      press(1'b0, 1'b1); expect_ds("b_start", 16'h0100, 3);
      repeat (9) @(negedge clk); cmp("b_pre_tick", int'(digits), 16'h0100);
      repeat (1) @(negedge clk); cmp("b_tick1", int'(digits), 16'h0059);
      repeat (589) @(negedge clk); expect_ds("b_599", 16'h0001, 3);
      repeat (1) @(negedge clk); expect_ds("b_600", 16'h0000, 5);
      cmp("b_600_flags", int'({running, done, alarm}), 3'b011);
      repeat (3) @(negedge clk); cmp("b_alarm_603", int'(alarm), 1);
      repeat (1) @(negedge clk); cmp("b_alarm_604", int'(alarm), 0);
      repeat (4) @(negedge clk); cmp("b_alarm_608", int'(alarm), 1);
      press(1'b0, 1'b1); expect_ds("b_ack", 16'h0000, 0);
      cmp("b_ack_alarm", int'(alarm), 0);

      // Pause keeps the prescaler phase.
      load(8'h00); load(8'h05); expect_ds("p_load", 16'h0005, 2);
      press(1'b0, 1'b1);
      repeat (21) @(negedge clk);
      press(1'b0, 1'b1); expect_ds("p_pause", 16'h0003, 4);
      repeat (50) @(negedge clk); expect_ds("p_held", 16'h0003, 4);
      press(1'b0, 1'b1);
      repeat (4) @(negedge clk); expect_ds("p_res4", 16'h0003, 3);
      repeat (1) @(negedge clk); cmp("p_res5", int'(digits), 16'h0002);
      repeat (19) @(negedge clk); expect_ds("p_res24", 16'h0001, 3);
      repeat (1) @(negedge clk); expect_ds("p_res25", 16'h0000, 5);
      press(1'b0, 1'b1); expect_ds("p_ack", 16'h0000, 0);

      // START with a zero count stays ARMED.
      load(8'h00); load(8'h00); expect_ds("z_armed", 16'h0000, 2);
      press(1'b0, 1'b1); expect_ds("z_start", 16'h0000, 2);

      // Coincident LOAD and START in RUN: START wins.
      load(8'h00); load(8'h30); expect_ds("c_load", 16'h0030, 2);
      press(1'b0, 1'b1); cmp("c_run", int'(state), 3);
      press(1'b1, 1'b1); expect_ds("c_both", 16'h0030, 4);
      press(1'b0, 1'b1); cmp("c_resume", int'(state), 3);
      repeat (7) @(negedge clk);

      // Asynchronous reset while running.
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      expect_ds("r_run", 16'h0000, 0);
      cmp("r_run_flags", int'({running, done, alarm, invalid}), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Top field accepts 0x99 but rejects a non-decimal nibble.
      load(8'h9A); expect_ds("t_9a", 16'h0000, 0);
      cmp("t_9a_inv", int'(invalid), 1);
      load(8'h99); expect_ds("t_99", 16'h9900, 1);
      cmp("t_99_inv", int'(invalid), 0);
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
